// File: rtl/cpu_trace_serializer.sv
// cpu_trace_serializer
// Turns one CPU write-back event (register or memory write) into an ASCII
// trace record streamed one character per clock:
//   register write: "^<time>@<pc>: $<reg> <= <data>#"
//   memory write:   "^<time>@<pc>: *<addr> <= <data>#"
// The FSM state names the field whose character is currently on char, and
// cnt_reg indexes the digit/nibble within that field.

module cpu_trace_serializer #(
    parameter logic [7:0] IDLE_CHAR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_kind,
    input  logic [15:0] in_time,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_reg,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [7:0]  char,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CARET,
        S_TIME,
        S_AT,
        S_PC,
        S_COLON,
        S_SP1,
        S_TAG,
        S_REG,
        S_ADDR,
        S_ARROW,
        S_DATA,
        S_HASH
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [2:0]  cnt_reg;
    logic [2:0]  cnt_next;
    logic [7:0]  char_reg;
    logic [7:0]  char_next;

    // Captured event fields; frozen for the whole record.
    logic        kind_reg;
    logic [15:0] time_reg;
    logic [31:0] pc_reg;
    logic [4:0]  reg_reg;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;

    logic        accept;
    logic [2:0]  time_start;
    logic [1:0]  reg_tens;
    logic [4:0]  reg_tens_x10;
    logic [3:0]  reg_units;
    logic [2:0]  reg_start;

    // Nibble 0..15 to ASCII: digits then lowercase a-f.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h57 + {4'h0, n};
    endfunction

    // Nibble idx of a 32-bit word, idx 0 being the most significant.
    function automatic logic [3:0] nib32(input logic [31:0] w, input logic [2:0] idx);
        logic [31:0] s;
        s = w << {idx, 2'b00};
        return s[31:28];
    endfunction

    // Digit idx of the 16-bit time field, idx 0 being the most significant.
    function automatic logic [3:0] nib16(input logic [15:0] w, input logic [1:0] idx);
        logic [15:0] s;
        s = w << {idx, 2'b00};
        return s[15:12];
    endfunction

    assign accept   = in_valid && in_ready;
    assign in_ready = (state_reg == S_IDLE) && reset;
    assign busy     = (state_reg != S_IDLE) || accept;
    assign char     = char_reg;

    // Index of the first time digit to print: skip leading zeros, keep the last digit.
    always_comb begin
        time_start = 3'd3;
        if (time_reg[15:12] != 4'h0) begin
            time_start = 3'd0;
        end else if (time_reg[11:8] != 4'h0) begin
            time_start = 3'd1;
        end else if (time_reg[7:4] != 4'h0) begin
            time_start = 3'd2;
        end
    end

    // Decimal split of the register number; a single-digit register starts at the units slot.
    always_comb begin
        reg_tens = 2'd0;
        if (reg_reg >= 5'd30) begin
            reg_tens = 2'd3;
        end else if (reg_reg >= 5'd20) begin
            reg_tens = 2'd2;
        end else if (reg_reg >= 5'd10) begin
            reg_tens = 2'd1;
        end
        case (reg_tens)
            2'd1:    reg_tens_x10 = 5'd10;
            2'd2:    reg_tens_x10 = 5'd20;
            2'd3:    reg_tens_x10 = 5'd30;
            default: reg_tens_x10 = 5'd0;
        endcase
        reg_units = 4'(reg_reg - reg_tens_x10);
        reg_start = (reg_tens == 2'd0) ? 3'd1 : 3'd0;
    end

    // Next field / digit position: each field runs its counter to its last index, then hands over.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_valid) begin
                    state_next = S_CARET;
                    cnt_next   = 3'd0;
                end
            end
            S_CARET: begin
                state_next = S_TIME;
                cnt_next   = time_start;
            end
            S_TIME: begin
                if (cnt_reg == 3'd3) begin
                    state_next = S_AT;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            S_AT: begin
                state_next = S_PC;
                cnt_next   = 3'd0;
            end
            S_PC: begin
                if (cnt_reg == 3'd7) begin
                    state_next = S_COLON;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            S_COLON: begin
                state_next = S_SP1;
            end
            S_SP1: begin
                state_next = S_TAG;
            end
            S_TAG: begin
                if (kind_reg) begin
                    state_next = S_ADDR;
                    cnt_next   = 3'd0;
                end else begin
                    state_next = S_REG;
                    cnt_next   = reg_start;
                end
            end
            S_REG: begin
                if (cnt_reg == 3'd1) begin
                    state_next = S_ARROW;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            S_ADDR: begin
                if (cnt_reg == 3'd7) begin
                    state_next = S_ARROW;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            S_ARROW: begin
                if (cnt_reg == 3'd3) begin
                    state_next = S_DATA;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            S_DATA: begin
                if (cnt_reg == 3'd7) begin
                    state_next = S_HASH;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            S_HASH: begin
                state_next = S_IDLE;
                cnt_next   = 3'd0;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // Character for the upcoming cycle, derived from the field/position being entered.
    always_comb begin
        char_next = IDLE_CHAR;
        case (state_next)
            S_IDLE:  char_next = IDLE_CHAR;
            S_CARET: char_next = 8'h5e;                              // '^'
            S_TIME:  char_next = hex_char(nib16(time_reg, cnt_next[1:0]));
            S_AT:    char_next = 8'h40;                              // '@'
            S_PC:    char_next = hex_char(nib32(pc_reg, cnt_next));
            S_COLON: char_next = 8'h3a;                              // ':'
            S_SP1:   char_next = 8'h20;                              // ' '
            S_TAG:   char_next = kind_reg ? 8'h2a : 8'h24;           // '*' or '$'
            S_REG: begin
                if (cnt_next == 3'd0) begin
                    char_next = 8'h30 + {6'h00, reg_tens};
                end else begin
                    char_next = 8'h30 + {4'h0, reg_units};
                end
            end
            S_ADDR:  char_next = hex_char(nib32(addr_reg, cnt_next));
            S_ARROW: begin
                case (cnt_next[1:0])
                    2'd1:    char_next = 8'h3c;                      // '<'
                    2'd2:    char_next = 8'h3d;                      // '='
                    default: char_next = 8'h20;                      // ' '
                endcase
            end
            S_DATA:  char_next = hex_char(nib32(data_reg, cnt_next));
            S_HASH:  char_next = 8'h23;                              // '#'
            default: char_next = IDLE_CHAR;
        endcase
    end

    // FSM state, registered character output and event capture; reset drops any record in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 3'd0;
            char_reg  <= IDLE_CHAR;
            kind_reg  <= 1'b0;
            time_reg  <= 16'h0000;
            pc_reg    <= 32'h0000_0000;
            reg_reg   <= 5'd0;
            addr_reg  <= 32'h0000_0000;
            data_reg  <= 32'h0000_0000;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            char_reg  <= char_next;
            if (accept) begin
                kind_reg <= in_kind;
                time_reg <= in_time;
                pc_reg   <= in_pc;
                reg_reg  <= in_reg;
                addr_reg <= in_addr;
                data_reg <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_serializer.sv
// Testbench for cpu_trace_serializer: the driver pushes each expected record
// into a character queue at accept time; an independent monitor pops and
// compares every non-idle character the DUT emits.

module tb_cpu_trace_serializer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_kind;
    logic [15:0] in_time;
    logic [31:0] in_pc;
    logic [4:0]  in_reg;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [7:0]  char;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_hash_cyc = 0;
    int          gap_last = -1;
    int          hash_cnt = 0;
    bit          in_rec = 0;
    logic [7:0]  exp_q[$];

    cpu_trace_serializer #(.IDLE_CHAR(8'h00)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_kind  (in_kind),
        .in_time  (in_time),
        .in_pc    (in_pc),
        .in_reg   (in_reg),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .char     (char),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    // Present one event, wait (bounded) for acceptance, queue its expected record.
    task automatic send(input logic kind, input logic [15:0] t, input logic [31:0] pc,
                        input logic [4:0] r, input logic [31:0] addr, input logic [31:0] data,
                        input string exp, input bit hold, input bit chk_busy);
        int n;
        int bcnt;
        logic [7:0] b;
        in_kind  = kind;
        in_time  = t;
        in_pc    = pc;
        in_reg   = r;
        in_addr  = addr;
        in_data  = data;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'h0, in_ready}, 32'h1);
            in_valid = 1'b0;
            return;
        end
        bcnt = busy ? 1 : 0;
        for (int i = 0; i < exp.len(); i++) begin
            b = exp[i];
            exp_q.push_back(b);
        end
        $display("send kind=%0d time=%h pc=%h reg=%0d addr=%h data=%h expect \"%s\"",
                 kind, t, pc, r, addr, data, exp);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        #1;
        check("latency_caret", {24'h0, char}, 32'h5e);
        if (chk_busy) begin
            while (busy && bcnt < 200) begin
                bcnt++;
                @(negedge clk);
                #1;
            end
            check("busy_cycles", bcnt, 31);
        end
    endtask

    // Monitor: every non-idle character must match the next queued one.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                in_rec = 0;
            end else if (char != 8'h00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stray_char: got %h required none", char);
                end else begin
                    e = exp_q.pop_front();
                    if (char !== e) begin
                        errors++;
                        $display("FAIL char_stream: got %h required %h", char, e);
                    end
                end
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_record: got %b required 0", in_ready);
                end
                if (char == 8'h5e) begin
                    in_rec   = 1;
                    gap_last = cyc - last_hash_cyc;
                end
                if (char == 8'h23) begin
                    in_rec        = 0;
                    last_hash_cyc = cyc;
                    hash_cnt++;
                end
            end else if (in_rec) begin
                checks++;
                errors++;
                $display("FAIL record_gap: got idle char required record char");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_kind  = 1'b0;
        in_time  = 16'h0;
        in_pc    = 32'h0;
        in_reg   = 5'd0;
        in_addr  = 32'h0;
        in_data  = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_char", {24'h0, char}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_ready", {31'h0, in_ready}, 32'h0);
        reset = 1'b1;
        #1;
        check("ready_after_release", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        #1;

        send(1'b0, 16'h0042, 32'h0000_3004, 5'd28, 32'h0, 32'hff00_ff00,
             "^42@00003004: $28 <= ff00ff00#", 1'b0, 1'b1);
        send(1'b1, 16'h1234, 32'h0000_300c, 5'd0, 32'h0000_1ffc, 32'h0000_abcd,
             "^1234@0000300c: *00001ffc <= 0000abcd#", 1'b0, 1'b0);
        send(1'b0, 16'h0000, 32'h0, 5'd0, 32'h0, 32'h0,
             "^0@00000000: $0 <= 00000000#", 1'b0, 1'b0);
        send(1'b0, 16'h0100, 32'h1234_5678, 5'd9, 32'h0, 32'hdead_beef,
             "^100@12345678: $9 <= deadbeef#", 1'b0, 1'b0);

        // Back-to-back with in_valid held high across both records.
        send(1'b0, 16'h9999, 32'h0000_000f, 5'd31, 32'h0, 32'h0123_4567,
             "^9999@0000000f: $31 <= 01234567#", 1'b1, 1'b0);
        send(1'b0, 16'h0007, 32'h0000_0010, 5'd10, 32'h0, 32'ha0a0_a0a0,
             "^7@00000010: $10 <= a0a0a0a0#", 1'b0, 1'b0);
        check("b2b_gap", gap_last, 2);

        send(1'b1, 16'h00a5, 32'habcd_ef01, 5'd0, 32'h8000_0000, 32'h0000_0001,
             "^a5@abcdef01: *80000000 <= 00000001#", 1'b0, 1'b0);

        // Abort a record in the PC field.
        send(1'b0, 16'h0042, 32'h1111_1111, 5'd5, 32'h0, 32'h2222_2222,
             "^42@11111111: $5 <= 22222222#", 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("abort_char", {24'h0, char}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_ready", {31'h0, in_ready}, 32'h0);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_after_release", {24'h0, char}, 32'h0);
        check("ready_after_abort", {31'h0, in_ready}, 32'h1);
        send(1'b1, 16'h5000, 32'hffff_fffc, 5'd0, 32'h0000_0020, 32'hffff_ffff,
             "^5000@fffffffc: *00000020 <= ffffffff#", 1'b0, 1'b0);

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
        check("record_count", hash_cnt, 8);
        check("final_char", {24'h0, char}, 32'h0);
        check("final_busy", {31'h0, busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_trace_serializer.md
Name: cpu_trace_serializer

Overview:
- Upstream source for the trace-format checker stage.
- Accepts one CPU write-back event per handshake: a register write or a memory write.
- Serializes each event as an ASCII record, one 8-bit character per clock, on the character stream the checker consumes.
- Record forms:
  - Register write: "^<time>@<pc>: $<reg> <= <data>#"
  - Memory write: "^<time>@<pc>: *<addr> <= <data>#"

Parameters:
- IDLE_CHAR, 8'h00: character driven on char whenever no record is being emitted. Must not be "^".

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset. reset==0 resets the block immediately.
- in_valid, input, 1: an event is presented on the in_* buses.
- in_ready, output, 1: block can accept an event. The event is accepted on a rising edge where in_valid && in_ready.
- in_kind, input, 1: event type. 0 = register write, 1 = memory write.
- in_time, input, 16: four BCD digits, most significant digit at [15:12].
- in_pc, input, 32: instruction address.
- in_reg, input, 5: destination register 0..31. Used when in_kind==0.
- in_addr, input, 32: memory address. Used when in_kind==1.
- in_data, input, 32: write data.
- char, output, 8: serialized character stream. Registered.
- busy, output, 1: high from the accept edge through the cycle "#" is driven.

Behaviour:
- Reset (reset==0):
  - char=IDLE_CHAR, busy=0, in_ready=0 while reset is asserted. in_ready becomes 1 in the first cycle after release.
  - A record in flight is abandoned. No "#" is emitted.
  - Captured fields are cleared.
- Handshake:
  - in_ready = (state==IDLE) && reset released.
  - On accept, all inputs are latched into internal registers. Input changes after accept have no effect.
- Latency:
  - "^" appears on char the cycle after the accept edge.
  - Each following character appears on consecutive cycles. No gaps inside a record.
- States:
  - IDLE: char=IDLE_CHAR. Go to CARET on accept.
  - CARET: emit "^".
  - TIME: emit time digits, most significant first.
    - Leading zero digits are suppressed.
    - At least one digit is always emitted, so 0000 gives "0".
    - Up to 4 digits.
  - AT: emit "@".
  - PC: emit 8 hex chars, most significant nibble first.
  - COLON: emit ":".
  - SP1: emit " ".
  - TAG: emit "$" if in_kind==0, else "*".
  - REG (kind 0): emit decimal in_reg, 1 or 2 digits, no leading zero.
    - Tens digit = 3 if reg≥30, 2 if ≥20, 1 if ≥10. No tens digit if reg<10.
    - Units digit = reg − 10×tens.
  - ADDR (kind 1): emit 8 hex chars of in_addr.
  - ARROW: emit " ", "<", "=", " " on 4 consecutive cycles.
  - DATA: emit 8 hex chars of in_data.
  - HASH: emit "#", then go to IDLE.
- Hex mapping:
  - Nibble 0–9 → "0"–"9" (8'h30+n).
  - Nibble 10–15 → "a"–"f" (8'h61+n−10). Lowercase only.
- Non-BCD time nibbles (>9) are emitted via the hex mapping ("a"–"f") with no error flag. This is intentional, to drive malformed records into the checker.
- A nibble/digit counter, 0..7, indexes the field and resets at each field entry.
- Record lengths: N = number of emitted time digits (1..4), R = number of reg digits (1..2).
  - Kind 0: 1+N+1+8+2+1+R+4+8+1 characters.
  - Kind 1: 1+N+1+8+2+1+8+4+8+1 characters.
- Back-to-back: IDLE lasts at least one cycle between records. At least one IDLE_CHAR always separates "#" from the next "^".
- in_valid held high during busy is ignored until IDLE. Events are never dropped or duplicated.
- Reset asserted on any cycle mid-record: char goes to IDLE_CHAR asynchronously. After release the next record starts clean with "^".

Test Plan:
- Register write. Time 16'h0042, pc 32'h00003004, reg 28, data 32'hff00ff00 → char sequence "^42@00003004: $28 <= ff00ff00#" (30 chars). "^" appears 1 cycle after accept. busy high for 31 cycles.
- Memory write. Time 16'h1234, pc 32'h0000300c, addr 32'h00001ffc, data 32'h0000abcd → "^1234@0000300c: *00001ffc <= 0000abcd#".
- Zero suppression. Time 16'h0000, reg 0, pc/data 0 → "^0@00000000: $0 <= 00000000#". Time 16'h0100 → "^100@...".
- Back-to-back. in_valid held high with two events → exactly two records. in_ready=0 throughout each record. Exactly one IDLE_CHAR between "#" and the second "^". Second record reflects the second event's data.
- Reset mid-record. reset=0 during the PC field → char=IDLE_CHAR immediately, busy=0. After release, a new event emits a complete record from "^". No stray "#".
- Non-BCD time. Time 16'h00a5 → "^a5@..." emitted with no error flag.
